// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone memory arbiter.
// State encoding doubles as the one-hot grant vector {M1,M0}.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_t;

  typedef logic [1:0] gnt_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog: counts strobe cycles without ack and flags a bus error
// for the owning master after TIMEOUT_CYCLES.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic s_cyc,
  input  logic s_stb,
  input  logic s_ack,
  input  gnt_t gnt,
  output logic expire,
  output gnt_t err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          active;

  assign active = s_cyc & s_stb & ~s_ack;
  assign expire = active && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Ownership always passes through IDLE (s_cyc low), so an owner change
  // clears the count via the !active term.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      err <= '0;
    end else begin
      err <= expire ? gnt : gnt_t'(2'b00);
      if (!active || expire)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone classic arbiter (core M0, host/loader M1) in front of the
// memory controller. Optional stall timeout enabled by defining ARB_TIMEOUT_EN.
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_i,
  output logic [DW-1:0] m0_dat_o,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_i,
  output logic [DW-1:0] m1_dat_o,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_ack,
  output gnt_t          gnt
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t state, state_nxt;
  logic       last, last_nxt;
  logic [1:0] blk;
  logic [1:0] req;
  logic       expire;
  gnt_t       err;

  assign gnt = gnt_t'(state);
  assign req = {m1_cyc & ~blk[1], m0_cyc & ~blk[0]};

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req[0] && (!req[1] || last == M1)) begin
          state_nxt = OWN0;
          last_nxt  = M0;
        end else if (req[1]) begin
          state_nxt = OWN1;
          last_nxt  = M1;
        end
      end
      OWN0:    if (!m0_cyc || expire) state_nxt = IDLE;
      OWN1:    if (!m1_cyc || expire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A timed-out master stays blocked until its cyc is seen low once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last  <= M1;
      blk   <= 2'b00;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      for (int n = 0; n < 2; n++) begin
        if (expire && gnt[n])
          blk[n] <= 1'b1;
        else if (!(n == 0 ? m0_cyc : m1_cyc))
          blk[n] <= 1'b0;
      end
    end
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    if (gnt[0]) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_stb;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_o = m0_dat_i;
    end else if (gnt[1]) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_stb;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_ack   = s_ack & gnt[0];
  assign m1_ack   = s_ack & gnt[1];
  assign m0_dat_o = gnt[0] ? s_dat_i : '0;
  assign m1_dat_o = gnt[1] ? s_dat_i : '0;

`ifdef ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .s_cyc (s_cyc),
    .s_stb (s_stb),
    .s_ack (s_ack),
    .gnt   (gnt),
    .expire(expire),
    .err   (err)
  );
`else
  assign expire = 1'b0;
  assign err    = 2'b00;
`endif

  assign m0_err = err[0];
  assign m1_err = err[1];

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter (timeout scenario under ARB_TIMEOUT_EN).
module tb_wb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_i, m0_dat_o;
  logic          m0_ack, m0_err;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_i, m1_dat_o;
  logic          m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic          s_ack;
  logic [1:0]    gnt;

  int checks = 0;
  int errors = 0;

  wb_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack), .gnt(gnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_i = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_i = '0;
    s_dat_i = 32'hDEAD_BEEF; s_ack = 1'b1;
    tick(); tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_cyc); end
    checks++; if ({m1_ack, m0_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {m1_ack, m0_ack}); end
    checks++; if ({m1_err, m0_err} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b want 00", {m1_err, m0_err}); end
    s_ack = 1'b0;
    reset = 1'b1;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4;
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL grant_latency: got %b want 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL first_grant: got %b want 01", gnt); end
    checks++; if (s_adr !== 32'h4) begin errors++; $display("FAIL first_adr: got %h want 4", s_adr); end
    m0_cyc = 0; m0_stb = 0;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL release_idle: got %b want 00", gnt); end
  endtask

  task automatic test_m1_burst();
    int n_ack = 0;
    logic ack_seen;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 0; m1_dat_i = 32'hA000_0000;
    for (int k = 0; k < 5 && gnt !== 2'b10; k++) tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL m1_grant: got %b want 10", gnt); end
    for (int c = 0; c < 40 && m1_adr < 10; c++) begin
      s_ack = c[0];
      s_dat_i = 32'h5500_0000 + c;
      #1;
      checks++;
      if (s_adr !== m1_adr || s_dat_o !== m1_dat_i || s_we !== 1'b1) begin
        errors++;
        $display("FAIL m1_route: adr %h dat %h we %b want adr %h dat %h we 1", s_adr, s_dat_o, s_we, m1_adr, m1_dat_i);
      end
      checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL m0_ack_leak: got %b want 0", m0_ack); end
      checks++; if (m1_dat_o !== 32'h5500_0000 + c) begin errors++; $display("FAIL m1_dat_o: got %h want %h", m1_dat_o, 32'h5500_0000 + c); end
      ack_seen = m1_ack;
      if (ack_seen) n_ack++;
      tick();
      if (ack_seen) begin
        m1_adr = m1_adr + 1;
        m1_dat_i = 32'hA000_0000 + m1_adr;
      end
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    checks++; if (n_ack !== 10) begin errors++; $display("FAIL m1_ack_count: got %0d want 10", n_ack); end
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL m1_release: got %b want 00", gnt); end
  endtask

  task automatic test_paused_burst();
    m1_cyc = 1; m1_stb = 0;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL pause_grant: got %b want 10", gnt); end
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h40; s_ack = 1;
    for (int c = 0; c < 11; c++) begin
      tick();
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL pause_hold: cycle %0d got %b want 10", c, gnt); end
      checks++; if (s_stb !== 1'b0 || m0_ack !== 1'b0) begin errors++; $display("FAIL pause_nonowner: stb %b m0_ack %b want 0 0", s_stb, m0_ack); end
    end
    s_ack = 0; m1_cyc = 0;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL pause_idle_gap: got %b want 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL pause_handover: got %b want 01", gnt); end
    checks++; if (s_adr !== 32'h40) begin errors++; $display("FAIL pause_m0_adr: got %h want 40", s_adr); end
    m0_cyc = 0; m0_stb = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    reset = 0;
    tick(); tick();
    reset = 1; m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_first: got %b want 01", gnt); end
    m0_cyc = 0; m0_stb = 0;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b want 00", gnt); end
    m0_cyc = 1; m0_stb = 1;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL tie_round_robin: got %b want 10", gnt); end
    m1_cyc = 0; m1_stb = 0;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL tie_idle2: got %b want 00", gnt); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL tie_waiter_served: got %b want 01", gnt); end
    m0_cyc = 0; m0_stb = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h20;
    tick();
    checks++; if (gnt !== 2'b01 || s_adr !== 32'h20) begin errors++; $display("FAIL mid_setup: gnt %b adr %h want 01 20", gnt, s_adr); end
    s_ack = 1;
    #1;
    checks++; if (m0_ack !== 1'b1) begin errors++; $display("FAIL mid_ack_before: got %b want 1", m0_ack); end
    reset = 0;
    tick();
    checks++; if (s_cyc !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL mid_reset: s_cyc %b gnt %b want 0 00", s_cyc, gnt); end
    checks++; if (m0_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack: got %b want 0", m0_ack); end
    reset = 1; s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k = 0;
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h80; s_ack = 0;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL to_grant: got %b want 01", gnt); end
    while (k < 40 && m0_err !== 1'b1) begin
      tick();
      k++;
    end
    checks++; if (k !== 16) begin errors++; $display("FAIL to_latency: got %0d cycles want 16", k); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL to_gnt: got %b want 00", gnt); end
    tick();
    checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b want 0", m0_err); end
    tick(); tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL to_blocked: got %b want 00", gnt); end
    m0_cyc = 0; m0_stb = 0;
    tick();
    m0_cyc = 1; m0_stb = 1;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL to_regrant: got %b want 01", gnt); end
    m0_cyc = 0; m0_stb = 0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h80; s_ack = 0;
    tick();
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (gnt !== 2'b01 || m0_err !== 1'b0) begin errors++; $display("FAIL hold_forever: gnt %b err %b want 01 0", gnt, m0_err); end
    end
    m0_cyc = 0; m0_stb = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_m1_burst();
    test_paused_burst();
    test_simultaneous();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
